// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types, constants and helpers for the 4-way round-robin mux arbiter.
package mux4_rr_arbiter_pkg;

  localparam int REQ_N = 4;
  localparam int SEL_W = 2;

  // IDLE: nobody owns the shared path. GRANT: exactly one owner, indexed by sel.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Binary index of the set bit in a one-hot vector; zero when the vector is empty.
  function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [REQ_N-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < REQ_N; i++) begin
      if (oh[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

  // One-hot vector with bit idx set.
  function automatic logic [REQ_N-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    return REQ_N'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational rotate-priority picker: searches ptr+1, ptr+2, ptr+3, ptr
// (mod 4) and reports the first requester whose mask bit is set.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [REQ_N-1:0] mask,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] win_idx,
  output logic             win_vld
);

  logic [REQ_N-1:0] win_oh;
  logic [SEL_W-1:0] cand;

  // Walk the candidates in rotated order and keep only the first hit; the
  // last step wraps back to ptr itself, so the previous winner ranks lowest.
  always_comb begin
    win_oh = '0;
    cand   = '0;
    for (int k = 1; k <= REQ_N; k++) begin
      cand = ptr + SEL_W'(k);
      if (mask[cand] && (win_oh == '0)) win_oh[cand] = 1'b1;
    end
  end

  assign win_idx = onehot_to_idx(win_oh);
  assign win_vld = |mask;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared 4-to-1 single-bit mux path.
// Grants one requester at a time, drives the select, registers the muxed bit,
// and bounds how long one owner may hold the path while others are waiting.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REQ_N-1:0] req,
  input  logic [REQ_N-1:0] d,
  output logic [REQ_N-1:0] gnt,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] sel,
  output logic             y,
  output logic             y_valid
);

  localparam int                CNT_W    = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_t       state, state_nxt;
  logic [SEL_W-1:0] ptr, ptr_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic [REQ_N-1:0] gnt_nxt;
  logic             gnt_valid_nxt;
  logic [SEL_W-1:0] sel_nxt;

  logic [REQ_N-1:0] owner_oh;
  logic             owner_req;
  logic [REQ_N-1:0] others;
  logic [REQ_N-1:0] pick_mask;
  logic [SEL_W-1:0] win_idx;
  logic             win_vld;
  logic             take_win;

  // While granted, the owner is masked out of the search. On a release the
  // owner's bit is already 0, so the same mask serves both release handover
  // and preemption with a single picker.
  assign owner_oh  = idx_to_onehot(sel);
  assign owner_req = |(req & owner_oh);
  assign others    = req & ~owner_oh;
  assign pick_mask = (state == GRANT) ? others : req;

  rr_pick4 u_pick (
    .mask    (pick_mask),
    .ptr     (ptr),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

  // Next-state decision: start, hand over, preempt, keep, or drop to idle.
  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    hold_nxt      = hold_cnt;
    gnt_nxt       = gnt;
    gnt_valid_nxt = gnt_valid;
    sel_nxt       = sel;
    take_win      = 1'b0;

    case (state)
      IDLE: begin
        if (win_vld) take_win = 1'b1;
      end
      GRANT: begin
        if (!owner_req) begin
          if (win_vld) begin
            take_win = 1'b1;
          end else begin
            state_nxt     = IDLE;
            gnt_nxt       = '0;
            gnt_valid_nxt = 1'b0;
            hold_nxt      = '0;
          end
        end else if ((hold_cnt == HOLD_LIM) && win_vld) begin
          take_win = 1'b1;
        end else if (hold_cnt != HOLD_LIM) begin
          hold_nxt = hold_cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt     = IDLE;
        gnt_nxt       = '0;
        gnt_valid_nxt = 1'b0;
        hold_nxt      = '0;
      end
    endcase

    if (take_win) begin
      state_nxt     = GRANT;
      gnt_nxt       = idx_to_onehot(win_idx);
      gnt_valid_nxt = 1'b1;
      sel_nxt       = win_idx;
      ptr_nxt       = win_idx;
      hold_nxt      = CNT_ONE;
    end
  end

  // Arbitration state and registered grant outputs; ptr resets to 3 so that
  // requester 0 is searched first after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= SEL_W'(REQ_N - 1);
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      sel       <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      hold_cnt  <= hold_nxt;
      gnt       <= gnt_nxt;
      gnt_valid <= gnt_valid_nxt;
      sel       <= sel_nxt;
    end
  end

  // Registered mux output, one cycle behind the grant it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y       <= 1'b0;
      y_valid <= 1'b0;
    end else begin
      y       <= gnt_valid ? d[sel] : 1'b0;
      y_valid <= gnt_valid;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: two instances (HOLD_MAX=4 and 1)
// share the same request/data stimulus; a behavioural model predicts each.
module tb_mux4_rr_arbiter;

  typedef struct packed {
    logic [3:0] gnt;
    logic       gv;
    logic [1:0] sel;
    logic       y;
    logic       yv;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] d;

  logic [3:0] gnt4, gnt1;
  logic       gv4, gv1;
  logic [1:0] sel4, sel1;
  logic       y4, y1;
  logic       yv4, yv1;

  int checks;
  int failures;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1, got0, got1;

  int   mOwner[2];
  int   mPtr[2];
  int   mHold[2];
  int   mSel[2];
  logic mGv[2];
  int   holdMax[2];

  mux4_rr_arbiter #(.HOLD_MAX(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .d         (d),
    .gnt       (gnt4),
    .gnt_valid (gv4),
    .sel       (sel4),
    .y         (y4),
    .y_valid   (yv4)
  );

  mux4_rr_arbiter #(.HOLD_MAX(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .d         (d),
    .gnt       (gnt1),
    .gnt_valid (gv1),
    .sel       (sel1),
    .y         (y1),
    .y_valid   (yv1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // First requester in round-robin order after pointer p, or -1 if none.
  function automatic int pickRr(logic [3:0] mask, int p);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (p + k) % 4;
      if (mask[i]) return i;
    end
    return -1;
  endfunction

  function automatic void modelReset();
    for (int m = 0; m < 2; m++) begin
      mOwner[m] = -1;
      mPtr[m]   = 3;
      mHold[m]  = 0;
      mSel[m]   = 0;
      mGv[m]    = 1'b0;
    end
  endfunction

  // Advance model m by one clock edge with req r and data dd, queue expectation.
  function automatic void modelStep(int m, logic [3:0] r, logic [3:0] dd);
    exp_t       e;
    logic [3:0] oth;
    int         w;
    e.y  = mGv[m] ? dd[mSel[m]] : 1'b0;
    e.yv = mGv[m];
    if (mOwner[m] < 0 || !r[mOwner[m]]) begin
      w = pickRr(r, mPtr[m]);
      if (w >= 0) begin
        mOwner[m] = w;
        mPtr[m]   = w;
        mHold[m]  = 1;
      end else begin
        mOwner[m] = -1;
      end
    end else begin
      oth = r & ~(4'b0001 << mOwner[m]);
      if (mHold[m] == holdMax[m] && oth != 4'b0000) begin
        w = pickRr(oth, mPtr[m]);
        mOwner[m] = w;
        mPtr[m]   = w;
        mHold[m]  = 1;
      end else if (mHold[m] < holdMax[m]) begin
        mHold[m] = mHold[m] + 1;
      end
    end
    if (mOwner[m] >= 0) mSel[m] = mOwner[m];
    mGv[m]  = (mOwner[m] >= 0);
    e.gnt   = mGv[m] ? (4'b0001 << mOwner[m]) : 4'b0000;
    e.gv    = mGv[m];
    e.sel   = 2'(mSel[m]);
    if (m == 0) q0.push_back(e);
    else        q1.push_back(e);
  endfunction

  // Drive inputs now (no wait) and predict the effect of the coming edge.
  task automatic driveCycle(input logic [3:0] r, input logic [3:0] dd);
    req = r;
    d   = dd;
    modelStep(0, r, dd);
    modelStep(1, r, dd);
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] dd);
    @(negedge clk);
    driveCycle(r, dd);
  endtask

  task automatic checkOutput(input string name, input exp_t got, input exp_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%b expected=%b", name, got, exp);
    end
  endtask

  // Monitor for the HOLD_MAX=4 instance.
  always @(posedge clk) begin
    #1;
    if (rst_n && q0.size() > 0) begin
      e0   = q0.pop_front();
      got0 = {gnt4, gv4, sel4, y4, yv4};
      checks++;
      if (got0 !== e0) begin
        failures++;
        $display("[TB] FAIL sb_hold4 t=%0t got gnt=%b gv=%b sel=%0d y=%b yv=%b expected gnt=%b gv=%b sel=%0d y=%b yv=%b",
                 $time, got0.gnt, got0.gv, got0.sel, got0.y, got0.yv, e0.gnt, e0.gv, e0.sel, e0.y, e0.yv);
      end
    end
  end

  // Monitor for the HOLD_MAX=1 instance.
  always @(posedge clk) begin
    #1;
    if (rst_n && q1.size() > 0) begin
      e1   = q1.pop_front();
      got1 = {gnt1, gv1, sel1, y1, yv1};
      checks++;
      if (got1 !== e1) begin
        failures++;
        $display("[TB] FAIL sb_hold1 t=%0t got gnt=%b gv=%b sel=%0d y=%b yv=%b expected gnt=%b gv=%b sel=%0d y=%b yv=%b",
                 $time, got1.gnt, got1.gv, got1.sel, got1.y, got1.yv, e1.gnt, e1.gv, e1.sel, e1.y, e1.yv);
      end
    end
  end

  initial begin
    logic [3:0] r;
    checks     = 0;
    failures   = 0;
    holdMax[0] = 4;
    holdMax[1] = 1;
    modelReset();

    rst_n = 1'b0;
    req   = 4'b1111;
    d     = 4'b1111;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_hold4", {gnt4, gv4, sel4, y4, yv4}, '0);
    checkOutput("reset_hold1", {gnt1, gv1, sel1, y1, yv1}, '0);

    @(negedge clk);
    rst_n = 1'b1;
    driveCycle(4'b1111, 4'b0101);

    $display("[TB] contention");
    repeat (20) applyStimulus(4'b1111, 4'($urandom_range(0, 15)));

    $display("[TB] lone requester");
    repeat (10) applyStimulus(4'b0100, 4'b0100);
    repeat (2)  applyStimulus(4'b0000, 4'($urandom_range(0, 15)));

    $display("[TB] release handover");
    repeat (2) applyStimulus(4'b0100, 4'($urandom_range(0, 15)));
    repeat (3) applyStimulus(4'b1010, 4'($urandom_range(0, 15)));

    $display("[TB] preemption boundary");
    repeat (6) applyStimulus(4'b0011, 4'($urandom_range(0, 15)));
    repeat (5) applyStimulus(4'b0001, 4'($urandom_range(0, 15)));

    $display("[TB] random traffic");
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      applyStimulus(r, 4'($urandom_range(0, 15)));
    end

    $display("[TB] mid-grant reset");
    repeat (3) applyStimulus(4'b1000, 4'b1000);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_hold4", {gnt4, gv4, sel4, y4, yv4}, '0);
    checkOutput("midreset_hold1", {gnt1, gv1, sel1, y1, yv1}, '0);
    modelReset();
    req = 4'b1010;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    driveCycle(4'b1010, 4'b0010);
    repeat (4) applyStimulus(4'b1010, 4'($urandom_range(0, 15)));

    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 2) == 0) r = 4'($urandom_range(0, 15));
      applyStimulus(r, 4'($urandom_range(0, 15)));
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("[TB] FAIL queue_drain got=%0d/%0d pending required=0/0", q0.size(), q1.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
